// File: rtl/rom_arbiter.sv
// Round-robin arbiter between instruction fetch (port 0) and data reads (port 1) for the
// single program ROM port, running the ROM ready handshake with a bounded timeout.
module rom_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] addr0,
    output logic        ack0,
    output logic [15:0] rdata0,
    input  logic        req1,
    input  logic [15:0] addr1,
    output logic        ack1,
    output logic [15:0] rdata1,
    output logic        err,
    output logic        mem_cs,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_data
);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    // QUIET drain | IDLE arbitrate | ISSUE cs pulse | WAIT_LOW/WAIT_HIGH handshake | RESP ack
    typedef enum logic [2:0] {
        QUIET,
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        abort_q, abort_d;
    logic        mem_cs_q, mem_cs_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err_q, err_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;
    logic        grant1;
    logic        go_resp;
    logic        timed_out;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        abort_d      = abort_q;
        mem_cs_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err_d        = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        grant1       = 1'b0;
        go_resp      = 1'b0;
        timed_out    = 1'b0;

        case (state_q)
            QUIET: begin
                if (cnt_q == 8'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            IDLE: begin
                if (req0 || req1) begin
                    grant1     = (req0 && req1) ? ~last_grant_q : req1;
                    owner_d    = grant1;
                    mem_addr_d = grant1 ? addr1 : addr0;
                    cnt_d      = '0;
                    abort_d    = 1'b0;
                    mem_cs_d   = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_LOW;
            WAIT_LOW, WAIT_HIGH: begin
                // every wait cycle counts, so the abort point is the same for stuck-high and stuck-low
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == TIMEOUT_C) begin
                    timed_out = 1'b1;
                    go_resp   = 1'b1;
                end else if (state_q == WAIT_LOW) begin
                    if (!mem_ready) state_d = WAIT_HIGH;
                end else if (mem_ready) begin
                    go_resp = 1'b1;
                end
            end
            RESP: begin
                last_grant_d = owner_q;
                cnt_d        = '0;
                state_d      = abort_q ? QUIET : IDLE;
            end
            default: state_d = QUIET;
        endcase

        if (go_resp) begin
            state_d = RESP;
            abort_d = timed_out;
            ack0_d  = ~owner_q;
            ack1_d  = owner_q;
            err_d   = timed_out;
            if (owner_q) rdata1_d = timed_out ? 16'h0000 : mem_data;
            else         rdata0_d = timed_out ? 16'h0000 : mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= QUIET;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            abort_q      <= 1'b0;
            mem_cs_q     <= 1'b0;
            mem_addr_q   <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            abort_q      <= abort_d;
            mem_cs_q     <= mem_cs_d;
            mem_addr_q   <= mem_addr_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign err      = err_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign mem_cs   = mem_cs_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: vector table, multi-cycle corner sequences and randomized rounds
// checked against a transaction-level round-robin/ROM model.
module tb_rom_arbiter;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic        ack0, ack1, err, mem_cs, mem_ready;
    logic [15:0] rdata0, rdata1, mem_addr, mem_data;

    int checks = 0;
    int errors = 0;

    rom_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .ack1(ack1), .rdata1(rdata1),
        .err(err), .mem_cs(mem_cs), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        case (a)
            16'd0:   return 16'h0028;
            16'd1:   return 16'h0005;
            16'd2:   return 16'h0029;
            16'd3:   return 16'h0000;
            default: return 16'hA000 | a;
        endcase
    endfunction

    // ROM: busy for rom_lat cycles after cs, then one cycle of valid data; 0 = never goes busy.
    // 16'hDEAD stands in for the undriven bus.
    int          rom_lat = 1;
    int          busy = 0;
    logic        valid = 1'b0;
    logic [15:0] lat_addr = '0;

    always @(posedge clk) begin
        if (mem_cs) begin
            lat_addr <= mem_addr;
            busy     <= rom_lat;
            valid    <= 1'b0;
        end else if (busy > 0) begin
            busy  <= busy - 1;
            valid <= (busy == 1);
        end else begin
            valid <= 1'b0;
        end
    end

    assign mem_ready = (busy == 0);
    assign mem_data  = valid ? rom_word(lat_addr) : 16'hDEAD;

    typedef struct {
        logic        do_rst;
        logic        r0;
        logic        r1;
        logic [15:0] a0;
        logic [15:0] a1;
        int          lat;
        int          exp_port;
        logic [15:0] exp_data;
        logic [15:0] exp_data2;
        logic        exp_err;
        int          exp_steps;
        int          exp_steps2;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check16({name, ".ctl"}, {12'h000, mem_cs, ack0, ack1, err}, 16'h0000);
        check16({name, ".mem_addr"}, mem_addr, 16'h0000);
        check16({name, ".rdata0"}, rdata0, 16'h0000);
        check16({name, ".rdata1"}, rdata1, 16'h0000);
    endtask

    task automatic do_reset(input string name);
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        check_reset_vals(name);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input string name, input int bound, output int n, output int cs_cnt,
                            output logic got);
        n = 0;
        cs_cnt = 0;
        got = 1'b0;
        while (!got && n < bound) begin
            step();
            n++;
            if (mem_cs) cs_cnt++;
            if (ack0 || ack1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no ack within %0d cycles", name, bound);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t  v;
        string nm;
        int    n, cs_cnt;
        logic  got;
        v  = vecs[i];
        nm = $sformatf("vec%0d", i);
        if (v.do_rst) do_reset({nm, ".rst"});
        rom_lat = v.lat;
        addr0 = v.a0;
        addr1 = v.a1;
        req0  = v.r0;
        req1  = v.r1;
        wait_ack(nm, 100, n, cs_cnt, got);
        if (got) begin
            check_int({nm, ".steps"}, n, v.exp_steps);
            check_int({nm, ".cs_pulses"}, cs_cnt, 1);
            check16({nm, ".ack0"}, 16'(ack0), 16'(v.exp_port == 0));
            check16({nm, ".ack1"}, 16'(ack1), 16'(v.exp_port == 1));
            check16({nm, ".err"}, 16'(err), 16'(v.exp_err));
            check16({nm, ".rdata"}, (v.exp_port == 0) ? rdata0 : rdata1, v.exp_data);
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
            if (v.r0 && v.r1) begin
                wait_ack({nm, ".second"}, 100, n, cs_cnt, got);
                if (got) begin
                    check_int({nm, ".steps2"}, n, v.exp_steps2);
                    check16({nm, ".ack_second"}, {14'h0, ack1, ack0},
                            (v.exp_port == 0) ? 16'h0002 : 16'h0001);
                    check16({nm, ".err2"}, 16'(err), 16'h0000);
                    check16({nm, ".rdata2"}, (v.exp_port == 0) ? rdata1 : rdata0, v.exp_data2);
                end
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, cs_cnt, cnt, since, mdl_last, pat, gap, nacks;
        int          ord[2];
        logic        got;
        logic [15:0] ra0, ra1;

        //            rst   r0    r1    a0        a1        lat  port data      data2     err   st  st2
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'd0,    16'd0,    1,   0, 16'h0028, 16'h0000, 1'b0, 6,  0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'd1,    16'd3,    1,   0, 16'h0005, 16'h0000, 1'b0, 6,  5};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'd0,    16'd7,    2,   1, 16'hA007, 16'h0000, 1'b0, 6,  0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'd0,    3,   0, 16'hB234, 16'h0000, 1'b0, 7,  0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'd5,    16'd6,    1,   1, 16'hA006, 16'hA005, 1'b0, 5,  5};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'd8,    16'd9,    2,   1, 16'hA009, 16'hA008, 1'b0, 6,  6};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'd2,    16'd0,    0,   0, 16'h0000, 16'h0000, 1'b1, TO+4, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'd0,    16'd4,    1,   1, 16'hA004, 16'h0000, 1'b0, 7,  0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'd0,    16'd10,   255, 1, 16'h0000, 16'h0000, 1'b1, TO+4, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'd11,   16'd12,   1,   0, 16'hA00B, 16'hA00C, 1'b0, 7,  5};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 16'd0,    16'd2,    1,   1, 16'h0029, 16'h0000, 1'b0, 6,  0};

        for (int i = 0; i < 10; i++) run_vec(i);

        // reset while the ROM is still busy in WAIT_HIGH: the interrupted read never acks
        rom_lat = 3;
        addr0 = 16'd3;
        req0 = 1'b1;
        for (int s = 1; s <= 4; s++) step();
        rst = 1'b1;
        step();
        check_reset_vals("rst_in_wait");
        rst = 1'b0;
        req0 = 1'b0;
        run_vec(10);

        // owner's address moves during WAIT_LOW; the latched address must win
        rom_lat = 1;
        addr0 = 16'd1;
        req0 = 1'b1;
        for (int s = 1; s <= 5; s++) begin
            step();
            if (s == 2) begin
                check16("addr_hold.cs", 16'(mem_cs), 16'h0001);
                check16("addr_hold.mem_addr", mem_addr, 16'h0001);
            end
            if (s == 3) addr0 = 16'd2;
        end
        check16("addr_hold.ack0", 16'(ack0), 16'h0001);
        check16("addr_hold.rdata0", rdata0, 16'h0005);
        check16("addr_hold.err", 16'(err), 16'h0000);
        req0 = 1'b0;

        // both ports requesting back to back for six transactions
        do_reset("rr.rst");
        rom_lat = 1;
        addr0 = 16'h0020;
        addr1 = 16'h0040;
        req0 = 1'b1;
        req1 = 1'b1;
        cnt = 0;
        since = 0;
        n = 0;
        while (cnt < 6 && n < 200) begin
            step();
            n++;
            since++;
            if (ack0 || ack1) begin
                check_int($sformatf("rr%0d.onehot", cnt), int'(ack0) + int'(ack1), 1);
                check_int($sformatf("rr%0d.port", cnt), int'(ack1), cnt % 2);
                check_int($sformatf("rr%0d.gap", cnt), since, (cnt == 0) ? 6 : 5);
                check16($sformatf("rr%0d.err", cnt), 16'(err), 16'h0000);
                if (ack0) begin
                    check16($sformatf("rr%0d.rdata0", cnt), rdata0, rom_word(addr0));
                    addr0 = addr0 + 16'd1;
                end else begin
                    check16($sformatf("rr%0d.rdata1", cnt), rdata1, rom_word(addr1));
                    addr1 = addr1 + 16'd1;
                end
                cnt++;
                since = 0;
            end
        end
        if (cnt < 6) begin
            checks++;
            errors++;
            $display("FAIL rr.count: got %0d acks expected 6", cnt);
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // randomized rounds against the round-robin model
        mdl_last = 1;
        for (int r = 0; r < 30; r++) begin
            pat = $urandom_range(1, 3);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            ra0 = 16'($urandom);
            ra1 = 16'($urandom);
            rom_lat = $urandom_range(1, 4);
            if (pat == 3) begin
                nacks  = 2;
                ord[0] = (mdl_last == 1) ? 0 : 1;
                ord[1] = 1 - ord[0];
            end else begin
                nacks  = 1;
                ord[0] = (pat == 1) ? 0 : 1;
                ord[1] = ord[0];
            end
            mdl_last = ord[nacks - 1];
            addr0 = ra0;
            addr1 = ra1;
            req0 = (pat != 2);
            req1 = (pat != 1);
            for (int k = 0; k < nacks; k++) begin
                wait_ack($sformatf("rnd%0d.%0d", r, k), 60, n, cs_cnt, got);
                if (got) begin
                    check_int($sformatf("rnd%0d.%0d.port", r, k), int'(ack1) - int'(ack0) + 1,
                              2 * ord[k]);
                    check16($sformatf("rnd%0d.%0d.err", r, k), 16'(err), 16'h0000);
                    check16($sformatf("rnd%0d.%0d.rdata", r, k),
                            (ord[k] == 0) ? rdata0 : rdata1,
                            rom_word((ord[k] == 0) ? ra0 : ra1));
                    if (ack0) req0 = 1'b0;
                    if (ack1) req1 = 1'b0;
                end
            end
            req0 = 1'b0;
            req1 = 1'b0;
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
